// File: rtl/ddr2_sdram_model.sv
// rtl/ddr2_sdram_model.sv - clock-accurate single-data-rate DDR2 SDRAM behavioural model
module ddr2_sdram_model #(
    parameter int DQ_BITS       = 16,
    parameter int ROW_BITS      = 13,
    parameter int COL_BITS      = 10,
    parameter int BANK_BITS     = 3,
    parameter int MEM_ADDR_BITS = 12,
    parameter int DEFAULT_CL    = 3
) (
    input  logic                   ck,
    input  logic                   reset,
    input  logic                   ck_n,
    input  logic                   cke,
    input  logic                   cs_n,
    input  logic                   ras_n,
    input  logic                   cas_n,
    input  logic                   we_n,
    input  logic [DQ_BITS/8-1:0]   dm_rdqs,
    input  logic [BANK_BITS-1:0]   ba,
    input  logic [ROW_BITS-1:0]    addr,
    inout  wire  [DQ_BITS-1:0]     dq,
    inout  wire  [DQ_BITS/8-1:0]   dqs,
    inout  wire  [DQ_BITS/8-1:0]   dqs_n,
    input  logic                   odt,
    output logic                   err
);
    localparam int NB = 2 ** BANK_BITS;

    logic [DQ_BITS-1:0]  mem [0:(1<<MEM_ADDR_BITS)-1] = '{default: '0};
    logic [ROW_BITS-1:0] open_row [NB];
    logic [NB-1:0]       bank_open;
    logic [2:0]          cl;
    logic                bl8;

    logic                busy, b_write, b_ap, b_bl8;
    logic [2:0]          b_cl;
    logic [BANK_BITS-1:0] b_bank;
    logic [COL_BITS-1:0] b_col;
    logic [4:0]          cnt;

    logic                dq_oe, dqs_oe, dqs_val;
    logic [DQ_BITS-1:0]  dq_out;

    logic                unused_pins;
    assign unused_pins = ck_n ^ odt;

    logic [2:0]          cmd;
    logic                cmd_ok, rw_cmd, accept, e_busy, e_write, e_ap, e_bl8;
    logic [2:0]          e_cl;
    logic [BANK_BITS-1:0] e_bank;
    logic [COL_BITS-1:0] e_col, col_k;
    logic [4:0]          e_c, first, blen;
    logic [2:0]          beat;
    logic                in_beats, pre, last, wr_en;
    logic [MEM_ADDR_BITS-1:0] mem_addr;

    // The e_* view merges a burst accepted this edge with one already in flight,
    // so CL=2 preambles can start on the accepting edge itself.
    always_comb begin
        cmd      = {ras_n, cas_n, we_n};
        cmd_ok   = cke && !cs_n;
        rw_cmd   = cmd_ok && (cmd == 3'b101 || cmd == 3'b100);
        accept   = rw_cmd && !busy && bank_open[ba];
        e_busy   = busy || accept;
        e_write  = accept ? !we_n : b_write;
        e_ap     = accept ? addr[10] : b_ap;
        e_bl8    = accept ? bl8 : b_bl8;
        e_cl     = accept ? cl : b_cl;
        e_bank   = accept ? ba : b_bank;
        e_col    = accept ? addr[COL_BITS-1:0] : b_col;
        e_c      = accept ? 5'd0 : cnt;
        first    = {2'b00, e_cl} - 5'd1;
        blen     = e_bl8 ? 5'd8 : 5'd4;
        beat     = 3'(e_c - first);
        in_beats = e_busy && (e_c >= first) && (e_c < first + blen);
        pre      = e_busy && !e_write && (e_c == first - 5'd1);
        last     = e_busy && (e_c == (e_write ? first + blen - 5'd1 : first + blen));
        col_k    = e_col;
        if (e_bl8) col_k[2:0] = e_col[2:0] + beat;
        else       col_k[1:0] = e_col[1:0] + beat[1:0];
        mem_addr = MEM_ADDR_BITS'({e_bank, open_row[e_bank], col_k});
        wr_en    = in_beats && e_write && !reset;
    end

    always_ff @(posedge ck) begin
        if (wr_en) begin
            for (int j = 0; j < DQ_BITS/8; j++) begin
                if (!dm_rdqs[j]) mem[mem_addr][8*j +: 8] <= dq[8*j +: 8];
            end
        end
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            bank_open <= '0;
            cl        <= 3'(DEFAULT_CL);
            bl8       <= 1'b0;
            busy      <= 1'b0;
            b_write   <= 1'b0;
            b_ap      <= 1'b0;
            b_bl8     <= 1'b0;
            b_cl      <= 3'd0;
            b_bank    <= '0;
            b_col     <= '0;
            cnt       <= 5'd0;
            dq_oe     <= 1'b0;
            dqs_oe    <= 1'b0;
            dqs_val   <= 1'b0;
            dq_out    <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (accept) begin
                busy    <= 1'b1;
                b_write <= !we_n;
                b_ap    <= addr[10];
                b_bl8   <= bl8;
                b_cl    <= cl;
                b_bank  <= ba;
                b_col   <= addr[COL_BITS-1:0];
            end
            if (e_busy) cnt <= e_c + 5'd1;
            if (pre) begin
                dqs_oe  <= 1'b1;
                dqs_val <= 1'b0;
            end
            if (in_beats && !e_write) begin
                dq_oe   <= 1'b1;
                dq_out  <= mem[mem_addr];
                dqs_oe  <= 1'b1;
                dqs_val <= !beat[0];
            end
            if (last) begin
                busy <= 1'b0;
                if (!e_write) begin
                    dq_oe  <= 1'b0;
                    dqs_oe <= 1'b0;
                end
                if (e_ap) bank_open[e_bank] <= 1'b0;
            end
            if (cmd_ok) begin
                case (cmd)
                    3'b011: begin
                        if (bank_open[ba]) err <= 1'b1;
                        else begin
                            bank_open[ba] <= 1'b1;
                            open_row[ba]  <= addr;
                        end
                    end
                    3'b010: begin
                        if (addr[10]) bank_open <= '0;
                        else          bank_open[ba] <= 1'b0;
                    end
                    3'b001: if (|bank_open) err <= 1'b1;
                    3'b000: begin
                        if (ba == '0) begin
                            if (addr[6:4] >= 3'd2 && addr[6:4] <= 3'd6 &&
                                (addr[2:0] == 3'd2 || addr[2:0] == 3'd3)) begin
                                cl  <= addr[6:4];
                                bl8 <= (addr[2:0] == 3'd3);
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    3'b101, 3'b100: if (!accept) err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign dq    = dq_oe  ? dq_out               : {DQ_BITS{1'bz}};
    assign dqs   = dqs_oe ? {(DQ_BITS/8){dqs_val}}  : {(DQ_BITS/8){1'bz}};
    assign dqs_n = dqs_oe ? {(DQ_BITS/8){!dqs_val}} : {(DQ_BITS/8){1'bz}};
endmodule

// File: tb/tb_ddr2_sdram_model.sv
// tb/tb_ddr2_sdram_model.sv - scoreboard bench for ddr2_sdram_model
module tb_ddr2_sdram_model;
    logic        ck = 1'b0;
    logic        reset, cke, cs_n, ras_n, cas_n, we_n, odt, err;
    logic [1:0]  dm;
    logic [2:0]  ba;
    logic [12:0] addr;
    wire  [15:0] dq_w;
    wire  [1:0]  dqs_w, dqsn_w;
    logic        tb_oe;
    logic [15:0] tb_dq;

    assign dq_w = tb_oe ? tb_dq : 16'hzzzz;
    pullup (dq_w);
    pullup (dqs_w);
    pullup (dqsn_w);

    ddr2_sdram_model dut (
        .ck(ck), .reset(reset), .ck_n(~ck), .cke(cke), .cs_n(cs_n),
        .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .dm_rdqs(dm), .ba(ba),
        .addr(addr), .dq(dq_w), .dqs(dqs_w), .dqs_n(dqsn_w), .odt(odt), .err(err)
    );

    always #5 ck = ~ck;

    int cyc = 0;
    always @(posedge ck) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [19:0] bus;
        string       tag;
    } exp_t;
    exp_t sb[$];

    int pass_cnt = 0;
    int total    = 0;
    int cl       = 3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        exp_t e;
        @(negedge ck);
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at < cyc) chk({e.tag, "_late"}, cyc, e.at);
            else chk(e.tag, {12'h0, dq_w, dqs_w, dqsn_w}, {12'h0, e.bus});
        end
    endtask

    task automatic push(input int at, input logic [19:0] bus, input string tag);
        exp_t e;
        e.at = at; e.bus = bus; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic cmd(input logic [2:0] c, input logic [2:0] b, input logic [12:0] a);
        cs_n = 1'b0; {ras_n, cas_n, we_n} = c; ba = b; addr = a;
        tick();
        cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
        chk({tag, "_drain"}, sb.size(), 0);
    endtask

    task automatic rd(input logic [2:0] b, input logic [9:0] col, input logic [63:0] dat,
                      input string tag);
        int t;
        t = cyc + 1;
        push(t + cl - 2, {16'hFFFF, 2'b00, 2'b11}, {tag, "_pre"});
        for (int k = 0; k < 4; k++)
            push(t + cl - 1 + k, {dat[16*k +: 16], (k % 2 == 0) ? 4'b1100 : 4'b0011},
                 $sformatf("%s_b%0d", tag, k));
        push(t + cl + 3, {16'hFFFF, 4'b1111}, {tag, "_rel"});
        cmd(3'b101, b, {3'b000, col});
        drain(tag);
    endtask

    task automatic wr(input logic [2:0] b, input logic [9:0] col, input logic [63:0] dat,
                      input logic [7:0] dmv);
        cmd(3'b100, b, {3'b000, col});
        repeat (cl - 2) tick();
        for (int k = 0; k < 4; k++) begin
            tb_oe = 1'b1; tb_dq = dat[16*k +: 16]; dm = dmv[2*k +: 2];
            tick();
        end
        tb_oe = 1'b0; dm = 2'b00;
    endtask

    task automatic err_pulse(input string tag);
        chk({tag, "_err"}, err, 1);
        tick();
        chk({tag, "_err_clr"}, err, 0);
    endtask

    initial begin
        int t;
        reset = 1'b1; cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111;
        odt = 1'b0; dm = 2'b00; ba = 3'd0; addr = 13'd0; tb_oe = 1'b0; tb_dq = 16'h0;
        tick(); tick();
        chk("rst_bus", {dq_w, dqs_w, dqsn_w}, {16'hFFFF, 4'b1111});
        chk("rst_err", err, 0);
        reset = 1'b0;
        tick();

        cmd(3'b000, 3'd0, 13'h032);
        chk("lmr_ok", err, 0);
        cmd(3'b011, 3'd1, 13'd5);
        chk("act_ok", err, 0);
        wr(3'd1, 10'd8, 64'h4444_3333_2222_1111, 8'h00);
        tick();
        rd(3'd1, 10'd8, 64'h4444_3333_2222_1111, "rd8");
        rd(3'd1, 10'd10, 64'h2222_1111_4444_3333, "rd10wrap");

        wr(3'd1, 10'd8, 64'h0000_0000_0000_ABCD, 8'b1111_1110);
        tick();
        rd(3'd1, 10'd8, 64'h4444_3333_2222_11CD, "rdmask");

        cmd(3'b101, 3'd2, 13'd8);
        err_pulse("rd_closed");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rd_closed_z", {dq_w, dqs_w, dqsn_w}, {16'hFFFF, 4'b1111});
        end
        cmd(3'b011, 3'd1, 13'd7);
        err_pulse("act_open");
        cmd(3'b001, 3'd0, 13'd0);
        err_pulse("ref_open");

        cmd(3'b000, 3'd0, 13'h052);
        chk("lmr_cl5", err, 0);
        cl = 5;
        rd(3'd1, 10'd8, 64'h4444_3333_2222_11CD, "rdcl5");
        cmd(3'b000, 3'd0, 13'h072);
        err_pulse("lmr_cl7");
        rd(3'd1, 10'd9, 64'h11CD_4444_3333_2222, "rdcl5b");

        t = cyc + 1;
        push(t + cl - 2, {16'hFFFF, 2'b00, 2'b11}, "rdrst_pre");
        push(t + cl - 1, {16'h11CD, 4'b1100}, "rdrst_b0");
        push(t + cl,     {16'h2222, 4'b0011}, "rdrst_b1");
        cmd(3'b101, 3'd1, 13'd8);
        drain("rdrst");
        reset = 1'b1;
        tick();
        chk("rdrst_rel", {dq_w, dqs_w, dqsn_w}, {16'hFFFF, 4'b1111});
        reset = 1'b0;
        cl = 3;
        tick();
        cmd(3'b101, 3'd1, 13'd8);
        err_pulse("rd_after_rst");
        for (int i = 0; i < 4; i++) tick();
        chk("rd_after_rst_z", {dq_w, dqs_w, dqsn_w}, {16'hFFFF, 4'b1111});

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
